// File: rtl/jt89_tone_pkg.sv
// Shared limits and constants for the jt89 tone bank.
package jt89_tone_pkg;

  localparam int CH_MIN      = 1;
  localparam int CH_MAX      = 8;
  localparam int CW_MIN      = 4;
  localparam int CW_MAX      = 16;
  // Periods at or below this value hold the output high (PCM playback).
  localparam int TONE_DC_MAX = 1;
  localparam int TONE_RST    = 0;

endpackage

// File: rtl/jt89_tone_ch.sv
// One square-wave tone channel: period register, down-counter, level and toggle strobe.
// Optional JT89_TONE_PHASE_RST_EN: a write also reloads the counter (phase reset).
module jt89_tone_ch
  import jt89_tone_pkg::*;
#(
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_en,
  input  logic          we,
  input  logic [CW-1:0] wr_tone,
  output logic          out,
  output logic          tgl
);

  logic [CW-1:0] tone_reg;
  logic [CW-1:0] cnt;
  logic          dc;
  logic          dc_exit;
  logic          wr_ld;

  assign dc      = tone_reg <= CW'(TONE_DC_MAX);
  assign dc_exit = we && dc && (wr_tone > CW'(TONE_DC_MAX));

`ifdef JT89_TONE_PHASE_RST_EN
  assign wr_ld = we;
`else
  assign wr_ld = 1'b0;
`endif

  // Reload always uses the pre-write tone_reg, so a same-clk write waits one period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_reg <= CW'(TONE_RST);
      cnt      <= '0;
      out      <= 1'b0;
      tgl      <= 1'b0;
    end else begin
      tgl <= 1'b0;
      if (we) tone_reg <= wr_tone;
      if (wr_ld) begin
        cnt <= wr_tone;
      end else if (clk_en) begin
        if (cnt != '0) begin
          cnt <= cnt - CW'(1);
        end else begin
          cnt <= tone_reg;
          if (dc) begin
            out <= 1'b1;
          end else begin
            out <= ~out;
            tgl <= 1'b1;
          end
        end
      end
      if (dc_exit) out <= 1'b1;
    end
  end

endmodule

// File: rtl/jt89_tone_bank.sv
// Bank of CH tone channels sharing one period write port and the clk_en cadence.
// Optional JT89_TONE_PHASE_RST_EN: writes also restart the target channel's counter.
module jt89_tone_bank
  import jt89_tone_pkg::*;
#(
  parameter int CH  = 3,
  parameter int CW  = 10,
  parameter int CHW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clk_en,
  input  logic           wr,
  input  logic [CHW-1:0] wr_ch,
  input  logic [CW-1:0]  wr_tone,
  output logic [CH-1:0]  out,
  output logic [CH-1:0]  tgl
);

  logic [CH-1:0] we;

  // Addresses at or above CH match no channel, so those writes are dropped.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign we[i] = wr && (wr_ch == CHW'(i));

    jt89_tone_ch #(.CW(CW)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .clk_en  (clk_en),
      .we      (we[i]),
      .wr_tone (wr_tone),
      .out     (out[i]),
      .tgl     (tgl[i])
    );
  end

endmodule

// File: tb/tb_jt89_tone_bank.sv
// Self-checking bench for jt89_tone_bank: directed timing scenarios plus random traffic
// against a per-channel behavioural model.
module tb_jt89_tone_bank;

  localparam int CH  = 3;
  localparam int CW  = 10;
  localparam int CHW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           clk_en = 1'b0;
  logic           wr = 1'b0;
  logic [CHW-1:0] wr_ch = '0;
  logic [CW-1:0]  wr_tone = '0;
  logic [CH-1:0]  out;
  logic [CH-1:0]  tgl;

  jt89_tone_bank #(.CH(CH), .CW(CW), .CHW(CHW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_en  (clk_en),
    .wr      (wr),
    .wr_ch   (wr_ch),
    .wr_tone (wr_tone),
    .out     (out),
    .tgl     (tgl)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int            m_tone [CH];
  int            m_cnt  [CH];
  logic [CH-1:0] m_out;
  logic [CH-1:0] m_tgl;

  function automatic void model_reset();
    for (int i = 0; i < CH; i++) begin
      m_tone[i] = 0;
      m_cnt[i]  = 0;
    end
    m_out = '0;
    m_tgl = '0;
  endfunction

  // One clock of the spec's channel rules, computed from the old state.
  function automatic void model_step(bit ce, bit w, int ch, int tone);
    for (int i = 0; i < CH; i++) begin
      int nc;
      bit no;
      bit ng;
      bit hit;
      nc  = m_cnt[i];
      no  = m_out[i];
      ng  = 1'b0;
      hit = w && (ch == i);
      if (ce) begin
        if (m_cnt[i] > 0) nc = m_cnt[i] - 1;
        else begin
          nc = m_tone[i];
          if (m_tone[i] < 2) no = 1'b1;
          else begin
            no = !m_out[i];
            ng = 1'b1;
          end
        end
      end
`ifdef JT89_TONE_PHASE_RST_EN
      if (hit) begin
        nc = tone;
        no = m_out[i];
        ng = 1'b0;
      end
`endif
      if (hit && m_tone[i] < 2 && tone >= 2) no = 1'b1;
      if (hit) m_tone[i] = tone;
      m_cnt[i] = nc;
      m_out[i] = no;
      m_tgl[i] = ng;
    end
  endfunction

  // Called at a falling edge; applies inputs over one rising edge, returns at the next falling edge.
  task automatic drive(input bit ce, input bit w, input int ch, input int tone);
    clk_en  = ce;
    wr      = w;
    wr_ch   = CHW'(ch);
    wr_tone = CW'(tone);
    @(posedge clk);
    model_step(ce, w, ch, tone);
    cyc++;
    @(negedge clk);
    clk_en = 1'b0;
    wr     = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_vec++;
    if (out !== '0 || tgl !== '0) begin
      n_err++;
      $display("FAIL reset_state out=%b tgl=%b expected out=000 tgl=000", out, tgl);
    end
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b0, 0, 0);
      n_vec++;
      if (out !== m_out || tgl !== m_tgl || out !== '1 || tgl !== '0) begin
        n_err++;
        $display("FAIL reset_dc cyc=%0d out=%b tgl=%b expected out=111 tgl=000", k, out, tgl);
      end
    end
  endtask

  task automatic test_period();
    int last;
    int ntog;
    do_reset();
    last = -1;
    ntog = 0;
    drive(1'b1, 1'b1, 0, 4);
    for (int k = 1; k <= 40; k++) begin
      drive(1'b1, 1'b0, 0, 0);
      n_vec++;
      if (out !== m_out || tgl !== m_tgl) begin
        n_err++;
        $display("FAIL period_model k=%0d out=%b tgl=%b expected out=%b tgl=%b", k, out, tgl, m_out, m_tgl);
      end
      if (tgl[0]) begin
        if (last >= 0) begin
          n_vec++;
          if (k - last != 5) begin
            n_err++;
            $display("FAIL period_interval got=%0d expected=5", k - last);
          end
        end
        last = k;
        ntog++;
      end
    end
    n_vec++;
    if (ntog != 8) begin
      n_err++;
      $display("FAIL period_count toggles=%0d expected=8", ntog);
    end
  endtask

  task automatic test_slow_en();
    int  last;
    bit  prev;
    int  nint;
    do_reset();
    last = -1;
    prev = 1'b0;
    nint = 0;
    drive(1'b0, 1'b1, 1, 2);
    for (int k = 0; k < 200; k++) begin
      drive(k % 16 == 0, 1'b0, 0, 0);
      n_vec++;
      if (out !== m_out || tgl !== m_tgl || (prev && tgl[1])) begin
        n_err++;
        $display("FAIL slow_en k=%0d out=%b tgl=%b expected out=%b tgl=%b", k, out, tgl, m_out, m_tgl);
      end
      if (tgl[1]) begin
        if (last >= 0) begin
          n_vec++;
          nint++;
          if (k - last != 48) begin
            n_err++;
            $display("FAIL slow_en_half got=%0d expected=48", k - last);
          end
        end
        last = k;
      end
      prev = tgl[1];
    end
    n_vec++;
    if (nint < 3) begin
      n_err++;
      $display("FAIL slow_en_count intervals=%0d expected>=3", nint);
    end
  endtask

  task automatic test_midcount();
    int t0, tw, t1, t2, exp1;
    bit found;
    do_reset();
    t1 = -1;
    t2 = -1;
    found = 1'b0;
    drive(1'b1, 1'b1, 0, 9);
    t0 = 0;
    for (int k = 1; k < 40 && !found; k++) begin
      drive(1'b1, 1'b0, 0, 0);
      if (tgl[0]) begin
        found = 1'b1;
        t0 = k;
      end
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL midcount_first_toggle got=none expected=toggle within 40 clk");
    end
    for (int k = 1; k <= 3; k++) drive(1'b1, 1'b0, 0, 0);
    tw = t0 + 4;
    drive(1'b1, 1'b1, 0, 3);
    for (int k = tw + 1; k < tw + 40 && t2 < 0; k++) begin
      drive(1'b1, 1'b0, 0, 0);
      n_vec++;
      if (out !== m_out || tgl !== m_tgl) begin
        n_err++;
        $display("FAIL midcount_model k=%0d out=%b tgl=%b expected out=%b tgl=%b", k, out, tgl, m_out, m_tgl);
      end
      if (tgl[0]) begin
        if (t1 < 0) t1 = k;
        else t2 = k;
      end
    end
`ifdef JT89_TONE_PHASE_RST_EN
    exp1 = tw + 4 - t0;
`else
    exp1 = 10;
`endif
    n_vec++;
    if (t1 - t0 != exp1 || t2 - t1 != 4) begin
      n_err++;
      $display("FAIL midcount_intervals got=%0d,%0d expected=%0d,4", t1 - t0, t2 - t1, exp1);
    end
  endtask

  task automatic test_bad_ch_and_reload();
    int  tr, t1, expi;
    bit  found;
    do_reset();
    drive(1'b1, 1'b1, 0, 5);
    for (int k = 0; k < 30; k++) begin
      drive(1'b1, $urandom_range(0, 1) == 1, 3, $urandom_range(0, 1023));
      n_vec++;
      if (out !== m_out || tgl !== m_tgl) begin
        n_err++;
        $display("FAIL bad_ch k=%0d out=%b tgl=%b expected out=%b tgl=%b", k, out, tgl, m_out, m_tgl);
      end
    end
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m_cnt[0] == 0) found = 1'b1;
      else drive(1'b1, 1'b0, 0, 0);
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL reload_wr_search got=no reload expected=reload within 20 clk");
    end
    tr = cyc + 1;
    drive(1'b1, 1'b1, 0, 2);
    t1 = -1;
    for (int k = 0; k < 20 && t1 < 0; k++) begin
      drive(1'b1, 1'b0, 0, 0);
      n_vec++;
      if (out !== m_out || tgl !== m_tgl) begin
        n_err++;
        $display("FAIL reload_wr_model out=%b tgl=%b expected out=%b tgl=%b", out, tgl, m_out, m_tgl);
      end
      if (tgl[0]) t1 = cyc;
    end
`ifdef JT89_TONE_PHASE_RST_EN
    expi = 3;
`else
    expi = 6;
`endif
    n_vec++;
    if (t1 - tr != expi) begin
      n_err++;
      $display("FAIL reload_wr_interval got=%0d expected=%0d", t1 - tr, expi);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      int tone;
      tone = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 12);
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3), tone);
      n_vec++;
      if (out !== m_out || tgl !== m_tgl) begin
        n_err++;
        $display("FAIL random k=%0d out=%b tgl=%b expected out=%b tgl=%b", k, out, tgl, m_out, m_tgl);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 1'b1, 0, 3);
    drive(1'b1, 1'b1, 1, 6);
    drive(1'b1, 1'b1, 2, 2);
    for (int k = 0; k < 10; k++) drive(1'b1, 1'b0, 0, 0);
    drive(1'b1, 1'b1, 0, 7);
    clk_en = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (out !== '0 || tgl !== '0) begin
      n_err++;
      $display("FAIL async_reset out=%b tgl=%b expected out=000 tgl=000", out, tgl);
    end
    @(negedge clk);
    @(negedge clk);
    clk_en = 1'b0;
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 1'b0, 0, 0);
      n_vec++;
      if (out !== m_out || tgl !== m_tgl || out !== '1) begin
        n_err++;
        $display("FAIL async_restart k=%0d out=%b tgl=%b expected out=111 tgl=000", k, out, tgl);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_period();
    test_slow_en();
    test_midcount();
    test_bad_ch_and_reload();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
